// File: rtl/udma_l2_responder.sv
// ============================================================================
//  Module      : udma_l2_responder
//  Description : L2 memory model serving a uDMA RX (write) port and a TX
//                (read) port from one single-port word memory. The two
//                ports are arbitrated round-robin, and at most one access
//                is performed per cycle.
//  Ports       : clk_i / rst_i          - clock, synchronous active-high reset
//                rx_l2_*                - write request/grant/addr/be/wdata
//                tx_l2_*                - read request/grant/addr/rdata/rvalid
//                stall_i                - forces both grants low
//                err_cnt_o              - saturating out-of-range access count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_l2_responder #(
   parameter int unsigned              L2_DATA_WIDTH = 32,
   parameter int unsigned              MEM_WORDS     = 1024,
   parameter logic [31:0]              BASE_ADDR     = 32'h1C00_0000,
   parameter logic [L2_DATA_WIDTH-1:0] ERR_RDATA     = 32'hDEAD_BEEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   // RX (write) port
   input  logic                       rx_l2_req_i,
   output logic                       rx_l2_gnt_o,
   input  logic [31:0]                rx_l2_addr_i,
   input  logic [L2_DATA_WIDTH/8-1:0] rx_l2_be_i,
   input  logic [L2_DATA_WIDTH-1:0]   rx_l2_wdata_i,
   // TX (read) port
   input  logic                       tx_l2_req_i,
   output logic                       tx_l2_gnt_o,
   input  logic [31:0]                tx_l2_addr_i,
   output logic [L2_DATA_WIDTH-1:0]   tx_l2_rdata_o,
   output logic                       tx_l2_rvalid_o,
   // control / status
   input  logic                       stall_i,
   output logic [15:0]                err_cnt_o
);

   localparam int unsigned c_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned c_BE_W = L2_DATA_WIDTH / 8;
   localparam logic [31:0] c_SPAN = 32'(4 * MEM_WORDS);

   logic [L2_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   logic                     r_pri;      // 0: RX wins a tie, 1: TX wins
   logic                     r_rvalid;
   logic [L2_DATA_WIDTH-1:0] r_rdata;
   logic [15:0]              r_err_cnt;

   logic [31:0]              w_rx_off;
   logic [31:0]              w_tx_off;
   logic                     w_rx_in;
   logic                     w_tx_in;
   logic [c_AW-1:0]          w_rx_idx;
   logic [c_AW-1:0]          w_tx_idx;
   logic                     w_rx_gnt;
   logic                     w_tx_gnt;
   logic                     w_wr_en;
   logic                     w_err_hit;
   logic                     w_both_req;
   logic                     w_unused_bits;

   // Subtracting the base first lets a single unsigned compare cover both
   // bounds: addresses below the base wrap to huge offsets.
   assign w_rx_off = rx_l2_addr_i - BASE_ADDR;
   assign w_tx_off = tx_l2_addr_i - BASE_ADDR;
   assign w_rx_in  = (w_rx_off < c_SPAN);
   assign w_tx_in  = (w_tx_off < c_SPAN);
   assign w_rx_idx = w_rx_off[c_AW+1:2];
   assign w_tx_idx = w_tx_off[c_AW+1:2];

   // Byte offset within the word is intentionally ignored.
   assign w_unused_bits = ^{w_rx_off[1:0], w_tx_off[1:0]};

   assign w_both_req = rx_l2_req_i && tx_l2_req_i;

   always_comb begin
      w_rx_gnt = 1'b0;
      w_tx_gnt = 1'b0;
      if (!stall_i) begin
         if (w_both_req) begin
            w_rx_gnt = !r_pri;
            w_tx_gnt =  r_pri;
         end else begin
            w_rx_gnt = rx_l2_req_i;
            w_tx_gnt = tx_l2_req_i;
         end
      end
   end

   assign w_wr_en   = w_rx_gnt && w_rx_in && !rst_i;
   assign w_err_hit = (w_rx_gnt && !w_rx_in) || (w_tx_gnt && !w_tx_in);

   // Memory array: no reset, byte-enabled writes.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         for (int b = 0; b < c_BE_W; b++) begin
            if (rx_l2_be_i[b]) begin
               r_mem[w_rx_idx][8*b +: 8] <= rx_l2_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Read pipeline, arbitration priority and error counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_err_cnt <= 16'h0000;
         r_pri     <= 1'b0;
      end else begin
         r_rvalid <= w_tx_gnt;
         if (w_tx_gnt) begin
            r_rdata <= w_tx_in ? r_mem[w_tx_idx] : ERR_RDATA;
         end
         // Only one grant per cycle, so at most one increment.
         if (w_err_hit && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
         end
         // A contested, unstalled cycle always grants the pri side, so
         // flipping hands the next tie to the loser.
         if (!stall_i && w_both_req) begin
            r_pri <= ~r_pri;
         end
      end
   end

   assign rx_l2_gnt_o    = w_rx_gnt;
   assign tx_l2_gnt_o    = w_tx_gnt;
   assign tx_l2_rvalid_o = r_rvalid;
   assign tx_l2_rdata_o  = r_rdata;
   assign err_cnt_o      = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_udma_l2_responder.sv
// ============================================================================
//  Module      : tb_udma_l2_responder
//  Description : Directed self-checking bench for udma_l2_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udma_l2_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_req;
   logic        rx_gnt;
   logic [31:0] rx_addr;
   logic [3:0]  rx_be;
   logic [31:0] rx_wdata;
   logic        tx_req;
   logic        tx_gnt;
   logic [31:0] tx_addr;
   logic [31:0] tx_rdata;
   logic        tx_rvalid;
   logic        stall;
   logic [15:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   udma_l2_responder dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .rx_l2_req_i    (rx_req),
      .rx_l2_gnt_o    (rx_gnt),
      .rx_l2_addr_i   (rx_addr),
      .rx_l2_be_i     (rx_be),
      .rx_l2_wdata_i  (rx_wdata),
      .tx_l2_req_i    (tx_req),
      .tx_l2_gnt_o    (tx_gnt),
      .tx_l2_addr_i   (tx_addr),
      .tx_l2_rdata_o  (tx_rdata),
      .tx_l2_rvalid_o (tx_rvalid),
      .stall_i        (stall),
      .err_cnt_o      (err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One granted write cycle; returns just after the write edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      rx_req = 1'b1; rx_addr = a; rx_wdata = d; rx_be = be;
      #1;
      chk("wr_gnt", {31'b0, rx_gnt}, 32'd1);
      tick();
      rx_req = 1'b0;
   endtask

   // One granted read cycle; returns just after the grant edge (rvalid high).
   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      tx_req = 1'b1; tx_addr = a;
      #1;
      chk("rd_gnt", {31'b0, tx_gnt}, 32'd1);
      tick();
      tx_req = 1'b0;
      chk("rd_rvalid", {31'b0, tx_rvalid}, 32'd1);
      chk(tag, tx_rdata, exp);
   endtask

   initial begin
      rst = 1'b1; rx_req = 1'b0; tx_req = 1'b0; stall = 1'b0;
      rx_addr = 32'h0; rx_be = 4'h0; rx_wdata = 32'h0; tx_addr = 32'h0;

      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst_rvalid", {31'b0, tx_rvalid}, 32'd0);
      chk("rst_rdata", tx_rdata, 32'h0);
      chk("rst_err", {16'b0, err_cnt}, 32'd0);
      chk("idle_gnts", {30'b0, rx_gnt, tx_gnt}, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- round-robin alternation ----------------
      rx_req = 1'b1; tx_req = 1'b1;
      rx_addr = 32'h1C00_0100; rx_be = 4'h0; rx_wdata = 32'h0;
      tx_addr = 32'h1C00_0104;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_rx_gnt", {31'b0, rx_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_tx_gnt", {31'b0, tx_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_not_both", {31'b0, rx_gnt & tx_gnt}, 32'd0);
         tick();
      end
      rx_req = 1'b0; tx_req = 1'b0;
      chk("rr_last_rvalid", {31'b0, tx_rvalid}, 32'd1);
      tick();

      // ---------------- write then read-after-write ----------------
      wr(32'h1C00_0010, 32'h1234_5678, 4'hF);
      rd(32'h1C00_0010, 32'h1234_5678, "raw_rdata");
      tick();
      chk("rvalid_one_cycle", {31'b0, tx_rvalid}, 32'd0);
      chk("rdata_hold", tx_rdata, 32'h1234_5678);

      // ---------------- byte enables ----------------
      wr(32'h1C00_0020, 32'hFFFF_FFFF, 4'hF);
      wr(32'h1C00_0020, 32'h0000_00AA, 4'b0001);
      rd(32'h1C00_0020, 32'hFFFF_FFAA, "be0_rdata");
      wr(32'h1C00_0020, 32'h0055_0000, 4'b0100);
      rd(32'h1C00_0020, 32'hFF55_FFAA, "be2_rdata");

      // ---------------- back-to-back reads ----------------
      tx_req = 1'b1; tx_addr = 32'h1C00_0010;
      tick();
      tx_addr = 32'h1C00_0020;
      chk("b2b_rvalid0", {31'b0, tx_rvalid}, 32'd1);
      chk("b2b_rdata0", tx_rdata, 32'h1234_5678);
      tick();
      tx_req = 1'b0;
      chk("b2b_rvalid1", {31'b0, tx_rvalid}, 32'd1);
      chk("b2b_rdata1", tx_rdata, 32'hFF55_FFAA);
      tick();
      chk("b2b_rvalid_end", {31'b0, tx_rvalid}, 32'd0);

      // ---------------- range boundaries ----------------
      wr(32'h1C00_0000, 32'hCAFE_F00D, 4'hF);
      wr(32'h1C00_0FFC, 32'h0BAD_C0DE, 4'hF);
      rd(32'h1C00_0FFC, 32'h0BAD_C0DE, "last_word_rdata");
      chk("last_word_err", {16'b0, err_cnt}, 32'd0);
      rd(32'h1C00_1000, 32'hDEAD_BEEF, "oor_rdata");
      chk("oor_rd_err", {16'b0, err_cnt}, 32'd1);
      wr(32'h1C00_1000, 32'h1111_1111, 4'hF);
      chk("oor_wr_err", {16'b0, err_cnt}, 32'd2);
      rd(32'h1C00_0000, 32'hCAFE_F00D, "oor_wr_no_alias");
      wr(32'h1BFF_FFFC, 32'h2222_2222, 4'hF);
      chk("below_base_err", {16'b0, err_cnt}, 32'd3);
      rd(32'h1C00_0FFC, 32'h0BAD_C0DE, "below_base_no_alias");

      // ---------------- stall holds priority ----------------
      rx_req = 1'b1; tx_req = 1'b1;
      rx_addr = 32'h1C00_0100; rx_be = 4'h0;
      tx_addr = 32'h1C00_0010;
      #1;
      chk("pre_stall_rx", {31'b0, rx_gnt}, 32'd1);
      chk("pre_stall_tx", {31'b0, tx_gnt}, 32'd0);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_gnts", {30'b0, rx_gnt, tx_gnt}, 32'd0);
         tick();
      end
      chk("stall_rvalid", {31'b0, tx_rvalid}, 32'd0);
      stall = 1'b0;
      #1;
      chk("post_stall_tx", {31'b0, tx_gnt}, 32'd1);
      chk("post_stall_rx", {31'b0, rx_gnt}, 32'd0);
      tick();
      chk("post_stall_rdata", tx_rdata, 32'h1234_5678);
      chk("post_stall_rx2", {31'b0, rx_gnt}, 32'd1);
      tick();
      rx_req = 1'b0; tx_req = 1'b0;
      tick();

      // ---------------- reset during a read grant ----------------
      rst = 1'b1;
      tx_req = 1'b1; tx_addr = 32'h1C00_0010;
      #1;
      chk("rst_rd_gnt", {31'b0, tx_gnt}, 32'd1);
      tick();
      tx_req = 1'b0;
      chk("rst_rd_rvalid", {31'b0, tx_rvalid}, 32'd0);
      chk("rst_rd_err", {16'b0, err_cnt}, 32'd0);
      chk("rst_rd_rdata", tx_rdata, 32'h0);
      // A write granted under reset must not land.
      rx_req = 1'b1; rx_addr = 32'h1C00_0010; rx_wdata = 32'h0; rx_be = 4'hF;
      #1;
      chk("rst_wr_gnt", {31'b0, rx_gnt}, 32'd1);
      tick();
      rx_req = 1'b0;
      rst = 1'b0;
      tick();
      chk("rst_rvalid_after", {31'b0, tx_rvalid}, 32'd0);
      rd(32'h1C00_0010, 32'h1234_5678, "rst_no_write");
      // Priority back to RX after reset.
      rx_req = 1'b1; tx_req = 1'b1; rx_be = 4'h0;
      #1;
      chk("rst_pri_rx", {31'b0, rx_gnt}, 32'd1);
      tick();
      rx_req = 1'b0; tx_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
